// File: rtl/aes_batch_scheduler.sv
// Batches up to SLOTS masked AES requests from two requesters onto one
// 64-bit-datapath Cipher core and returns recombined, requester-tagged results.
module aes_batch_scheduler #(
  parameter int unsigned SLOTS       = 2,
  parameter int unsigned GATHER_WAIT = 8,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [255:0] req_pt0,
  input  logic [255:0] req_pt1,
  input  logic [255:0] req_key0,
  input  logic [255:0] req_key1,
  input  logic [63:0]  r_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_ct0,
  output logic [127:0] res_ct1,
  output logic         res_id,
  output logic         err,
  output logic         cph_rst,
  output logic [63:0]  cph_in0,
  output logic [63:0]  cph_in1,
  output logic [63:0]  cph_key0,
  output logic [63:0]  cph_key1,
  output logic [63:0]  cph_r,
  input  logic [63:0]  cph_out0,
  input  logic [63:0]  cph_out1,
  input  logic         cph_done
);
  localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned NS = 1 << SW;
  localparam int unsigned HW = SW + 1;
  localparam logic [HW-1:0] LAST_HALF = HW'(2 * SLOTS - 1);
  localparam logic [SW:0]   LAST_FILL = (SW + 1)'(SLOTS - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  typedef enum logic [2:0] {IDLE, GATHER, LOAD, WAIT_DONE, DRAIN, RESP} state_t;

  state_t         state;
  logic           ptr;
  logic [SW:0]    fill;
  logic [15:0]    gcnt;
  logic [HW-1:0]  hcnt;
  logic [9:0]     wcnt;
  logic [SW-1:0]  rptr;
  logic [127:0]   s_pt0 [NS];
  logic [127:0]   s_pt1 [NS];
  logic [127:0]   s_key0[NS];
  logic [127:0]   s_key1[NS];
  logic [NS-1:0]  s_valid;
  logic [NS-1:0]  s_id;
  logic [63:0]    o0[2*NS];
  logic [63:0]    o1[2*NS];

  // Half A = {W1,W0}, half B = {W3,W2} with W0 the most significant word.
  function automatic logic [63:0] half_of(input logic [127:0] b, input logic hb);
    return hb ? {b[31:0], b[63:32]} : {b[95:64], b[127:96]};
  endfunction

  function automatic logic [127:0] join_halves(input logic [63:0] ha, input logic [63:0] hb);
    return {ha[31:0], ha[63:32], hb[31:0], hb[63:32]};
  endfunction

  logic          accept, gnt, gsel, has_next;
  logic [127:0]  g_pt0, g_pt1, g_key0, g_key1;
  logic [HW-1:0] nxt;
  logic [SW-1:0] nslot, rnext;

  always_comb begin
    accept   = !rst && (state == IDLE || (state == GATHER && fill < (SW + 1)'(SLOTS)));
    gsel     = (&req_valid) ? ptr : req_valid[1];
    gnt      = accept && (|req_valid);
    req_ready = {gnt && gsel, gnt && !gsel};
    g_pt0    = gsel ? req_pt0[255:128]  : req_pt0[127:0];
    g_pt1    = gsel ? req_pt1[255:128]  : req_pt1[127:0];
    g_key0   = gsel ? req_key0[255:128] : req_key0[127:0];
    g_key1   = gsel ? req_key1[255:128] : req_key1[127:0];
    nxt      = hcnt + HW'(1);
    nslot    = nxt[HW-1:1];
    rnext    = rptr + SW'(1);
    has_next = (rptr != LAST_SLOT) && s_valid[rnext];
  end

  assign cph_r   = r_in;
  assign res_ct0 = res_valid ? join_halves(o0[{rptr, 1'b0}], o0[{rptr, 1'b1}]) : '0;
  assign res_ct1 = res_valid ? join_halves(o1[{rptr, 1'b0}], o1[{rptr, 1'b1}]) : '0;
  assign res_id  = res_valid & s_id[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      fill      <= '0;
      gcnt      <= '0;
      hcnt      <= '0;
      wcnt      <= '0;
      rptr      <= '0;
      s_valid   <= '0;
      s_id      <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      cph_rst   <= 1'b1;
      cph_in0   <= '0;
      cph_in1   <= '0;
      cph_key0  <= '0;
      cph_key1  <= '0;
      for (int unsigned i = 0; i < NS; i++) begin
        s_pt0[i] <= '0; s_pt1[i] <= '0; s_key0[i] <= '0; s_key1[i] <= '0;
      end
      for (int unsigned i = 0; i < 2 * NS; i++) begin
        o0[i] <= '0; o1[i] <= '0;
      end
    end else begin
      err      <= 1'b0;
      cph_in0  <= '0;
      cph_in1  <= '0;
      cph_key0 <= '0;
      cph_key1 <= '0;
      case (state)
        IDLE: if (gnt) begin
          s_pt0[0] <= g_pt0; s_pt1[0] <= g_pt1; s_key0[0] <= g_key0; s_key1[0] <= g_key1;
          s_valid[0] <= 1'b1;
          s_id[0]    <= gsel;
          ptr        <= !gsel;
          fill       <= (SW + 1)'(1);
          gcnt       <= '0;
          if (SLOTS == 1) begin
            // Single-slot batches skip GATHER, so the first half comes straight from the request.
            state    <= LOAD;
            cph_rst  <= 1'b0;
            hcnt     <= '0;
            cph_in0  <= half_of(g_pt0, 1'b0);
            cph_in1  <= half_of(g_pt1, 1'b0);
            cph_key0 <= half_of(g_key0, 1'b0);
            cph_key1 <= half_of(g_key1, 1'b0);
          end else begin
            state <= GATHER;
          end
        end
        GATHER: begin
          if (gnt) begin
            s_pt0[fill[SW-1:0]]  <= g_pt0;
            s_pt1[fill[SW-1:0]]  <= g_pt1;
            s_key0[fill[SW-1:0]] <= g_key0;
            s_key1[fill[SW-1:0]] <= g_key1;
            s_valid[fill[SW-1:0]] <= 1'b1;
            s_id[fill[SW-1:0]]    <= gsel;
            ptr  <= !gsel;
            fill <= fill + (SW + 1)'(1);
          end
          gcnt <= gcnt + 16'd1;
          if ((gnt && fill == LAST_FILL) || gcnt == 16'(GATHER_WAIT - 1)) begin
            state    <= LOAD;
            cph_rst  <= 1'b0;
            hcnt     <= '0;
            cph_in0  <= half_of(s_pt0[0], 1'b0);
            cph_in1  <= half_of(s_pt1[0], 1'b0);
            cph_key0 <= half_of(s_key0[0], 1'b0);
            cph_key1 <= half_of(s_key1[0], 1'b0);
          end
        end
        LOAD: begin
          if (hcnt == LAST_HALF) begin
            state <= WAIT_DONE;
            wcnt  <= '0;
          end else begin
            hcnt <= nxt;
            if (s_valid[nslot]) begin
              cph_in0  <= half_of(s_pt0[nslot], nxt[0]);
              cph_in1  <= half_of(s_pt1[nslot], nxt[0]);
              cph_key0 <= half_of(s_key0[nslot], nxt[0]);
              cph_key1 <= half_of(s_key1[nslot], nxt[0]);
            end
          end
        end
        WAIT_DONE: begin
          if (cph_done) begin
            o0[0] <= cph_out0;
            o1[0] <= cph_out1;
            hcnt  <= HW'(1);
            state <= DRAIN;
          end else if (wcnt == 10'(TIMEOUT - 1)) begin
            err     <= 1'b1;
            cph_rst <= 1'b1;
            s_valid <= '0;
            state   <= IDLE;
          end else begin
            wcnt <= wcnt + 10'd1;
          end
        end
        DRAIN: begin
          o0[hcnt] <= cph_out0;
          o1[hcnt] <= cph_out1;
          if (hcnt == LAST_HALF) begin
            cph_rst   <= 1'b1;
            res_valid <= 1'b1;
            rptr      <= '0;
            state     <= RESP;
          end else begin
            hcnt <= nxt;
          end
        end
        RESP: if (res_ready) begin
          // Slots fill contiguously, so the first invalid slot ends the batch.
          if (has_next) begin
            rptr <= rnext;
          end else begin
            res_valid <= 1'b0;
            s_valid   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
